// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris front end (window generator and gradient stage).
package harris_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned WIN_SIZE = 6;
    localparam int unsigned GRAD_W   = 16;
    localparam int unsigned NUM_LB   = WIN_SIZE - 1;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t [0:WIN_SIZE-1][0:WIN_SIZE-1] window_t;
    typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/window_gen_if.sv
// Pixel stream in / 6x6 window out bundle for window_gen.
// WINGEN_SOF_EN adds the sof start-of-frame strobe.
interface window_gen_if #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
);
    import harris_pkg::*;

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    pixel_t           pix_in;
    logic             pix_valid;
`ifdef WINGEN_SOF_EN
    logic             sof;
`endif
    window_t          window;
    logic             win_valid;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    logic             frame_done;

    modport master (
        output pix_in, pix_valid,
`ifdef WINGEN_SOF_EN
        output sof,
`endif
        input  window, win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_in, pix_valid,
`ifdef WINGEN_SOF_EN
        input  sof,
`endif
        output window, win_valid, win_row, win_col, frame_done
    );

endinterface

// File: rtl/line_buffer.sv
// One image row of delay: read-before-write register array indexed by column.
module line_buffer #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Old contents leave before the new pixel lands in the same slot.
    assign dout = mem_q[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= din;
        end
    end

endmodule

// File: rtl/window_gen.sv
// Streaming 6x6 sliding-window generator feeding the Sobel stage.
// Optional WINGEN_SOF_EN: sof with pix_valid restarts the frame at (0,0).
module window_gen
    import harris_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic       clk,
    input  logic       reset,
    window_gen_if.slave bus
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col_q, col_d, col_cur_c;
    logic [ROW_W-1:0] row_q, row_d, row_cur_c;
    logic [ROW_W-1:0] wrow_q, wrow_d;
    logic [COL_W-1:0] wcol_q, wcol_d;
    window_t          win_q, win_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             accept_c, restart_c, lb_en_c, last_col_c, last_row_c;
    pixel_t           lb_din  [NUM_LB];
    pixel_t           lb_dout [NUM_LB];

    assign accept_c = bus.pix_valid;
`ifdef WINGEN_SOF_EN
    assign restart_c = bus.pix_valid & bus.sof;
`else
    assign restart_c = 1'b0;
`endif
    assign lb_en_c    = accept_c & reset;
    assign col_cur_c  = restart_c ? '0 : col_q;
    assign row_cur_c  = restart_c ? '0 : row_q;
    assign last_col_c = (col_cur_c == COL_W'(IMG_W - 1));
    assign last_row_c = (row_cur_c == ROW_W'(IMG_H - 1));

    // Five chained row delays: lbk presents pixel (r-1-k, c).
    assign lb_din[0] = bus.pix_in;
    for (genvar k = 0; k < NUM_LB; k++) begin : g_lb
        if (k > 0) begin : g_chain
            assign lb_din[k] = lb_dout[k-1];
        end
        line_buffer #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_lb (
            .clk  (clk),
            .en   (lb_en_c),
            .addr (col_cur_c),
            .din  (lb_din[k]),
            .dout (lb_dout[k])
        );
    end

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (accept_c) begin
            col_d   = last_col_c ? '0 : col_cur_c + COL_W'(1);
            row_d   = !last_col_c ? row_cur_c :
                      (last_row_c ? '0 : row_cur_c + ROW_W'(1));
            wrow_d  = row_cur_c;
            wcol_d  = col_cur_c;
            // Windows straddling a row boundary never qualify.
            valid_d = (row_cur_c >= ROW_W'(WIN_SIZE - 1)) &&
                      (col_cur_c >= COL_W'(WIN_SIZE - 1));
            done_d  = last_row_c && last_col_c;
            win_d[0] = {win_q[0][1:WIN_SIZE-1], lb_dout[4]};
            win_d[1] = {win_q[1][1:WIN_SIZE-1], lb_dout[3]};
            win_d[2] = {win_q[2][1:WIN_SIZE-1], lb_dout[2]};
            win_d[3] = {win_q[3][1:WIN_SIZE-1], lb_dout[1]};
            win_d[4] = {win_q[4][1:WIN_SIZE-1], lb_dout[0]};
            win_d[5] = {win_q[5][1:WIN_SIZE-1], bus.pix_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q   <= '0;
            row_q   <= '0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.window     = win_q;
    assign bus.win_valid  = valid_q;
    assign bus.win_row    = wrow_q;
    assign bus.win_col    = wcol_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on an 8x8 image: ramp frames, gaps, reset, back-to-back, sof.
module tb_window_gen;
    import harris_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned H = 8;
    localparam int unsigned NPIX = W * H;

    typedef struct {
        logic [2:0] row;
        logic [2:0] col;
        logic       valid;
        logic       done;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   n_pulse;
    int   last_r, last_c;
    int   last_pix;
    vec_t vecs [NPIX];

    window_gen_if #(.IMG_W(W), .IMG_H(H)) bus ();

    window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-window compare against pixel(r-5+i, c-5+j) = base + row*W + col.
    task automatic chk_win(input int r, input int c, input int base);
        int bad_i, bad_j;
        logic [31:0] act, exp;
        bad_i = -1;
        bad_j = -1;
        act = '0;
        exp = '0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                if (bad_i < 0 &&
                    32'(bus.window[i][j]) !== 32'(base + (r - 5 + i) * W + (c - 5 + j))) begin
                    bad_i = i;
                    bad_j = j;
                    act = 32'(bus.window[i][j]);
                    exp = 32'(base + (r - 5 + i) * W + (c - 5 + j));
                end
            end
        end
        n_vec++;
        if (bad_i >= 0) begin
            n_err++;
            $display("FAIL window[%0d][%0d] at (%0d,%0d): got %0d expected %0d",
                     bad_i, bad_j, r, c, act, exp);
        end
    endtask

    task automatic send(input pixel_t p, input logic v);
        bus.pix_in    = p;
        bus.pix_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        send(pixel_t'($urandom), 1'b0);
        chk("idle_valid", 32'(bus.win_valid), 32'd0);
        chk("idle_row_hold", 32'(bus.win_row), 32'(last_r));
        chk("idle_col_hold", 32'(bus.win_col), 32'(last_c));
        chk("idle_w55_hold", 32'(bus.window[5][5]), 32'(last_pix));
    endtask

    task automatic apply_vec(input int idx, input int base);
        send(pixel_t'(base + idx), 1'b1);
        chk("win_valid", 32'(bus.win_valid), 32'(vecs[idx].valid));
        chk("win_row", 32'(bus.win_row), 32'(vecs[idx].row));
        chk("win_col", 32'(bus.win_col), 32'(vecs[idx].col));
        chk("frame_done", 32'(bus.frame_done), 32'(vecs[idx].done));
        if (vecs[idx].valid) chk_win(int'(vecs[idx].row), int'(vecs[idx].col), base);
        if (idx == 45) begin
            chk("first_w00", 32'(bus.window[0][0]), 32'(base + 0));
            chk("first_w23", 32'(bus.window[2][3]), 32'(base + 19));
            chk("first_w55", 32'(bus.window[5][5]), 32'(base + 45));
        end
        if (bus.win_valid === 1'b1) n_pulse++;
        last_r   = int'(vecs[idx].row);
        last_c   = int'(vecs[idx].col);
        last_pix = (base + idx) % 256;
    endtask

    task automatic run_frame(input int base, input bit gaps);
        n_pulse = 0;
        for (int idx = 0; idx < int'(NPIX); idx++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) idle();
            end
            apply_vec(idx, base);
        end
        chk("pulse_count", 32'(n_pulse), 32'd9);
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_valid", 32'(bus.win_valid), 32'd0);
        chk("rst_row", 32'(bus.win_row), 32'd0);
        chk("rst_col", 32'(bus.win_col), 32'd0);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_window", 32'(bus.window != '0), 32'd0);
        last_r   = 0;
        last_c   = 0;
        last_pix = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_pulse = 0;
        reset = 1'b0;
        bus.pix_in = '0;
        bus.pix_valid = 1'b0;
`ifdef WINGEN_SOF_EN
        bus.sof = 1'b0;
`endif
        for (int idx = 0; idx < int'(NPIX); idx++) begin
            vecs[idx].row   = 3'(idx / W);
            vecs[idx].col   = 3'(idx % W);
            vecs[idx].valid = (idx / W >= 5) && (idx % W >= 5);
            vecs[idx].done  = (idx == int'(NPIX) - 1);
        end

        repeat (2) @(posedge clk);
        do_reset();

        // Gapless ramp, then a back-to-back frame offset by 100.
        run_frame(0, 1'b0);
        run_frame(100, 1'b0);

        // Same ramp with random idle cycles between pixels.
        run_frame(0, 1'b1);

        // Partial frame of junk up to (3,2), reset, then a clean frame.
        for (int idx = 0; idx <= 26; idx++) send(pixel_t'((idx * 37 + 200) % 256), 1'b1);
        do_reset();
        run_frame(0, 1'b0);

`ifdef WINGEN_SOF_EN
        // Truncated frame of 20 pixels, then sof on the 21st restarts at (0,0).
        for (int idx = 0; idx < 20; idx++) begin
            send(pixel_t'(idx + 50), 1'b1);
            chk("trunc_done", 32'(bus.frame_done), 32'd0);
        end
        bus.sof = 1'b1;
        n_pulse = 0;
        apply_vec(0, 0);
        bus.sof = 1'b0;
        for (int idx = 1; idx < int'(NPIX); idx++) apply_vec(idx, 0);
        chk("sof_pulse_count", 32'(n_pulse), 32'd9);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
